// File: rtl/pf_pkg.sv
// Shared types and sizing helper for the pulse scheduler.
package pf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } pf_state_t;

  // Bits needed to hold the larger of the two phase lengths.
  function automatic int cnt_width(input int width, input int gap);
    int m;
    m = (width > gap) ? width : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pf_sched_m_rr_arb.sv
// Round-robin picker: first set pend bit strictly after ptr, wrapping modulo N.
module rr_arb_m #(
  parameter int N = 4
) (
  input  logic [N-1:0]         pend,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_vld,
  output logic [$clog2(N)-1:0] gnt_id
);

  localparam int IW = $clog2(N);

  // Scan farthest-first so the nearest candidate after ptr overwrites the rest.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = N; k >= 1; k--) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (pend[idx[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/pf_sched_m.sv
// Shares one pulse-former among N edge-triggered sources with round-robin
// arbitration, fixed pulse width and a minimum inter-pulse gap.
module pf_sched_m
  import pf_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 4,
  parameter int GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         clr,
  output logic                 out,
  output logic [$clog2(N)-1:0] id,
  output logic [N-1:0]         pend,
  output logic                 busy,
  output logic [N-1:0]         ovf
);

  localparam int IW = $clog2(N);
  localparam int CW = cnt_width(WIDTH, GAP);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("pf_sched_m: N must be in 2..16");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("pf_sched_m: WIDTH must be >= 1");
    end
    if (GAP < 1) begin : g_bad_gap
      $error("pf_sched_m: GAP must be >= 1");
    end
  endgenerate

  pf_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  req_q;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  ovf_q, ovf_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic          out_q;
  logic          grant;
  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic [N-1:0]  gnt_mask;
  logic [N-1:0]  ev;

  rr_arb_m #(.N(N)) u_arb (
    .pend    (pend_q),
    .ptr     (ptr_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  // The enum member GAP is shadowed by the parameter, hence the qualified names.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant   = 1'b0;
    case (state_q)
      pf_pkg::IDLE: begin
        if (en && gnt_vld) grant = 1'b1;
      end
      pf_pkg::PULSE: begin
        if (cnt_q == '0) begin
          state_d = pf_pkg::GAP;
          cnt_d   = CW'(GAP - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      pf_pkg::GAP: begin
        if (cnt_q == '0) begin
          if (en && gnt_vld) grant = 1'b1;
          else               state_d = pf_pkg::IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = pf_pkg::IDLE;
    endcase
    if (grant) begin
      state_d = pf_pkg::PULSE;
      cnt_d   = CW'(WIDTH - 1);
    end
  end

  assign gnt_mask = grant ? (N'(1) << gnt_id) : '0;
  assign ptr_d    = grant ? gnt_id : ptr_q;
  assign id_d     = grant ? gnt_id : id_q;

  // A fresh event outranks both the grant clear and clr so it is never lost.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign ev[gi]     = req[gi] & ~req_q[gi];
      assign pend_d[gi] = ev[gi]       ? 1'b1 :
                          gnt_mask[gi] ? 1'b0 :
                          clr[gi]      ? 1'b0 : pend_q[gi];
      assign ovf_d[gi]  = ev[gi] & pend_q[gi] & ~gnt_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    req_q <= req;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= pf_pkg::IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= '0;
      ptr_q   <= IW'(N - 1);
      id_q    <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      out_q   <= (state_d == pf_pkg::PULSE);
    end
  end

  assign out  = out_q;
  assign id   = id_q;
  assign pend = pend_q;
  assign ovf  = ovf_q;
  assign busy = (state_q != pf_pkg::IDLE);

endmodule

// File: tb/tb_pf_sched_m.sv
// Directed bench for pf_sched_m with N=4, WIDTH=4, GAP=2.
module tb_pf_sched_m;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] clr;
  logic       out;
  logic [1:0] id;
  logic [3:0] pend;
  logic       busy;
  logic [3:0] ovf;

  int total = 0;
  int bad   = 0;

  pf_sched_m #(.N(4), .WIDTH(4), .GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .req   (req),
    .clr   (clr),
    .out   (out),
    .id    (id),
    .pend  (pend),
    .busy  (busy),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Steps until out is high; returns the number of edges taken (bounded).
  task automatic wait_high(input string tag, output int n);
    n = 0;
    while (out !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, out, 1);
  endtask

  // Counts edges while out stays high (bounded).
  task automatic high_len(output int n);
    n = 0;
    while (out === 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    int seen_out;
    rst_n = 1'b0; en = 1'b1; req = 4'b0000; clr = 4'b0000;
    repeat (3) step();
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", id, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    step();

    // Single event on channel 2: latency, width, gap, busy fall.
    req = 4'b0100; step();
    chk("t1_pend", pend, 4'b0100);
    chk("t1_out_pre", out, 0);
    step();
    chk("t1_out", out, 1);
    chk("t1_id", id, 2);
    chk("t1_pend_clr", pend, 0);
    chk("t1_busy", busy, 1);
    high_len(n);
    chk("t1_width", n, 4);
    chk("t1_busy_gap", busy, 1);
    step();
    chk("t1_busy_gap2", busy, 1);
    step();
    chk("t1_busy_fall", busy, 0);
    req = 4'b0000;

    // Fresh reset so channel 0 has first priority; three simultaneous events.
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req = 4'b1011; step();
    chk("t2_pend", pend, 4'b1011);
    step();
    chk("t2_id0", id, 0);
    chk("t2_pend0", pend, 4'b1010);
    high_len(n);
    chk("t2_width0", n, 4);
    wait_high("t2_rise1", n);
    chk("t2_gap01", n, 2);
    chk("t2_id1", id, 1);
    chk("t2_pend1", pend, 4'b1000);
    high_len(n);
    chk("t2_width1", n, 4);
    wait_high("t2_rise3", n);
    chk("t2_gap13", n, 2);
    chk("t2_id3", id, 3);
    chk("t2_pend3", pend, 4'b0000);
    high_len(n);
    chk("t2_width3", n, 4);
    req = 4'b0000;
    step(); step();
    chk("t2_idle", busy, 0);

    // Wrap-around: grant 1 with pend=0011 pending next goes to 0.
    req = 4'b0010; step(); step();
    chk("t3_id1", id, 1);
    req = 4'b0000; step();
    req = 4'b0011; step();
    chk("t3_pend", pend, 4'b0011);
    wait_high("t3_fall_skip", n);
    high_len(n);
    wait_high("t3_rise0", n);
    chk("t3_gap", n, 2);
    chk("t3_wrap_id", id, 0);

    // Duplicate event on pending channel 1 merges and flags ovf once.
    req = 4'b0001; step();
    req = 4'b0011; step();
    chk("t4_ovf", ovf, 4'b0010);
    step();
    chk("t4_ovf_clear", ovf, 4'b0000);
    high_len(n);
    wait_high("t4_rise1", n);
    chk("t4_id1", id, 1);
    high_len(n);
    step(); step();
    chk("t4_single_busy", busy, 0);
    chk("t4_single_pend", pend, 0);

    // Event coincident with clr keeps the bit; en low holds grants.
    en = 1'b0;
    req = 4'b0001; step();
    req = 4'b0011; clr = 4'b0010; step();
    chk("t5_evt_over_clr", pend, 4'b0010);
    step();
    chk("t5_clr", pend, 4'b0000);
    clr = 4'b0000;
    req = 4'b1011; step();
    chk("t5_pend3", pend, 4'b1000);
    seen_out = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out === 1'b1) seen_out = 1;
    end
    chk("t5_en_hold", seen_out, 0);
    en = 1'b1; step();
    chk("t5_en_out", out, 1);
    chk("t5_en_id", id, 3);
    en = 1'b0;
    high_len(n);
    chk("t5_en_drop_width", n, 4);
    step(); step();
    chk("t5_en_idle", busy, 0);

    // Reset in the second cycle of a pulse discards everything.
    en = 1'b1; req = 4'b0000; step();
    req = 4'b0100; step(); step();
    chk("t6_out", out, 1);
    chk("t6_id", id, 2);
    req = 4'b0101; step();
    chk("t6_pend", pend, 4'b0001);
    rst_n = 1'b0; step();
    chk("t6_rst_out", out, 0);
    chk("t6_rst_pend", pend, 0);
    chk("t6_rst_id", id, 0);
    step();
    rst_n = 1'b1; step(); step();
    chk("t7_held_pend", pend, 0);
    chk("t7_held_out", out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
